cluster_rate_meter: RTL



---
 rtl/gem_led_pkg.sv | 48 ++++
 rtl/cluster_rate_meter_if.sv | 32 +++
 rtl/cluster_rate_meter_rate_bar_encoder.sv | 60 ++++++
 rtl/cluster_rate_meter.sv | 117 +++++++++++
 4 files changed

// File: rtl/gem_led_pkg.sv
// Shared constants and elaboration-time helpers for the GEM LED path.
// Holds the bar width shared with the LED controller, the gate-length
// calculation and the rate threshold table generator.
package gem_led_pkg;

    localparam int unsigned LED_BAR_WIDTH = 8;

    // Gate window length in clock cycles for 2^speedup_log2 windows per second.
    function automatic longint unsigned gate_cycles(input int unsigned clk_freq,
                                                    input int unsigned speedup_log2);
        return 64'(clk_freq) >> speedup_log2;
    endfunction

    // Largest value representable in a width-bit unsigned word.
    function automatic longint unsigned max_value(input int unsigned width);
        longint unsigned lim;
        if (width >= 64) begin
            lim = '1;
        end else begin
            lim = (64'd1 << width) - 64'd1;
        end
        return lim;
    endfunction

    // Threshold k of the bar: decades (1, 10, 100, ...) or linear steps,
    // clamped so it always fits the rate word.
    function automatic longint unsigned bar_threshold(input int unsigned     k,
                                                      input bit              logarithmic,
                                                      input longint unsigned step,
                                                      input int unsigned     width);
        longint unsigned lim;
        longint unsigned t;
        lim = max_value(width);
        if (logarithmic) begin
            t = 64'd1;
            for (int unsigned i = 0; i < k; i++) begin
                // Stop growing once past the clamp so the product cannot wrap.
                if (t <= lim) begin
                    t = t * 64'd10;
                end
            end
        end else begin
            t = (64'(k) + 64'd1) * step;
        end
        return (t > lim) ? lim : t;
    endfunction

endpackage

// File: rtl/cluster_rate_meter_if.sv
// Data bundle of the cluster rate meter.
//   increment_i    : clusters seen this cycle (unsigned)
//   rate_o         : last measured rate in Hz
//   progress_bar_o : thermometer bar, bit 0 = lowest threshold
//   update_o       : one-cycle pulse when a new window's bar is presented
// slave = the meter itself, master = the producer/consumer around it.
interface cluster_rate_meter_if #(
    parameter int unsigned INCREMENTER_WIDTH = 8,
    parameter int unsigned COUNTER_WIDTH     = 32,
    parameter int unsigned BAR_WIDTH         = 8
);

    logic [INCREMENTER_WIDTH-1:0] increment_i;
    logic [COUNTER_WIDTH-1:0]     rate_o;
    logic [BAR_WIDTH-1:0]         progress_bar_o;
    logic                         update_o;

    modport master (
        output increment_i,
        input  rate_o,
        input  progress_bar_o,
        input  update_o
    );

    modport slave (
        input  increment_i,
        output rate_o,
        output progress_bar_o,
        output update_o
    );

endinterface

// File: rtl/cluster_rate_meter_rate_bar_encoder.sv
// Registered rate -> thermometer comparator bank.
//   clock, reset_n : clock, synchronous active-low reset
//   rate_i         : rate to display, sampled when valid_i is high
//   valid_i        : a new rate is present on rate_i
//   bar_o          : bar_o[k] = (rate_i >= threshold k), held between updates
//   update_o       : one-cycle pulse accompanying each new bar value
module rate_bar_encoder
    import gem_led_pkg::*;
#(
    parameter int unsigned RATE_WIDTH  = 32,
    parameter int unsigned BAR_WIDTH   = LED_BAR_WIDTH,
    parameter int unsigned LOGARITHMIC = 1,
    parameter int unsigned BAR_STEP    = 100
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic                  valid_i,
    output logic [BAR_WIDTH-1:0]  bar_o,
    output logic                  update_o
);

    logic [BAR_WIDTH-1:0] hit_c;
    logic [BAR_WIDTH-1:0] bar_q;
    logic [BAR_WIDTH-1:0] bar_d;
    logic                 update_q;
    logic                 update_d;

    // One constant comparator per LED; monotonic thresholds give a thermometer code.
    for (genvar k = 0; k < BAR_WIDTH; k++) begin : g_thr
        localparam logic [RATE_WIDTH-1:0] THR =
            RATE_WIDTH'(bar_threshold(32'(k), (LOGARITHMIC != 0), 64'(BAR_STEP), RATE_WIDTH));
        assign hit_c[k] = (rate_i >= THR);
    end

    // Next-state: capture a new bar only when a rate arrives.
    always_comb begin
        bar_d    = bar_q;
        update_d = 1'b0;
        if (valid_i) begin
            bar_d    = hit_c;
            update_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bar_q    <= '0;
            update_q <= 1'b0;
        end else begin
            bar_q    <= bar_d;
            update_q <= update_d;
        end
    end

    assign bar_o    = bar_q;
    assign update_o = update_q;

endmodule

// File: rtl/cluster_rate_meter.sv
// Cluster rate meter: accumulates per-BX cluster counts over a fixed gate
// window, scales the window sum to Hz and drives a thermometer LED bar.
//   clock   : fabric clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of cluster_rate_meter_if (increment in; rate,
//             progress bar and update pulse out)
// Timing: window closes at T, rate_o updates at T+1, bar and update_o at T+2.
module cluster_rate_meter
    import gem_led_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY     = 40079000,
    parameter int unsigned SPEEDUP_LOG2      = 4,
    parameter int unsigned COUNTER_WIDTH     = 32,
    parameter int unsigned INCREMENTER_WIDTH = 8,
    parameter int unsigned BAR_WIDTH         = LED_BAR_WIDTH,
    parameter int unsigned LOGARITHMIC       = 1,
    parameter int unsigned BAR_STEP          = 100
) (
    input  logic                 clock,
    input  logic                 reset_n,
    cluster_rate_meter_if.slave  bus
);

    localparam longint unsigned GATE      = gate_cycles(CLK_FREQUENCY, SPEEDUP_LOG2);
    localparam int unsigned     GCW       = (GATE > 64'd2) ? $clog2(GATE) : 2;
    localparam logic [GCW-1:0]  GATE_LAST = GCW'(GATE - 64'd1);
    localparam int unsigned     ACC_EXT_W = COUNTER_WIDTH + 1;
    localparam int unsigned     SCALE_W   = COUNTER_WIDTH + SPEEDUP_LOG2;

    // The three-stage pipeline must drain before the next window closes.
    if (GATE < 64'd3) begin : g_gate_too_short
        $error("cluster_rate_meter: gate window shorter than 3 cycles");
    end

    logic [GCW-1:0]           gate_cnt_q, gate_cnt_d;
    logic [COUNTER_WIDTH-1:0] acc_q, acc_d;
    logic [COUNTER_WIDTH-1:0] win_sum_q, win_sum_d;
    logic                     win_vld_q, win_vld_d;
    logic [COUNTER_WIDTH-1:0] rate_q, rate_d;
    logic                     rate_vld_q, rate_vld_d;

    logic                     close_c;
    logic [ACC_EXT_W-1:0]     sum_wide_c;
    logic [COUNTER_WIDTH-1:0] sum_sat_c;
    logic [SCALE_W-1:0]       scaled_c;
    logic                     scale_ovf_c;

    assign close_c = (gate_cnt_q == GATE_LAST);

    // Saturating accumulate: one extra bit catches the carry out.
    assign sum_wide_c = {1'b0, acc_q} + ACC_EXT_W'(bus.increment_i);
    assign sum_sat_c  = sum_wide_c[COUNTER_WIDTH] ? '1 : sum_wide_c[COUNTER_WIDTH-1:0];

    // Scale to Hz; anything landing above the rate word saturates.
    assign scaled_c    = SCALE_W'(win_sum_q) << SPEEDUP_LOG2;
    assign scale_ovf_c = ((scaled_c >> COUNTER_WIDTH) != '0);

    // Next-state for gate counter, accumulator and scaling stage.
    always_comb begin
        gate_cnt_d = gate_cnt_q + GCW'(1);
        acc_d      = sum_sat_c;
        win_sum_d  = win_sum_q;
        win_vld_d  = 1'b0;
        rate_d     = rate_q;
        rate_vld_d = 1'b0;

        // The closing cycle's increment belongs to the window being closed.
        if (close_c) begin
            gate_cnt_d = '0;
            acc_d      = '0;
            win_sum_d  = sum_sat_c;
            win_vld_d  = 1'b1;
        end

        if (win_vld_q) begin
            rate_d     = scale_ovf_c ? '1 : scaled_c[COUNTER_WIDTH-1:0];
            rate_vld_d = 1'b1;
        end
    end

    // State registers; reset discards any partial window.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            gate_cnt_q <= '0;
            acc_q      <= '0;
            win_sum_q  <= '0;
            win_vld_q  <= 1'b0;
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            acc_q      <= acc_d;
            win_sum_q  <= win_sum_d;
            win_vld_q  <= win_vld_d;
            rate_q     <= rate_d;
            rate_vld_q <= rate_vld_d;
        end
    end

    assign bus.rate_o = rate_q;

    // Bar stage.
    rate_bar_encoder #(
        .RATE_WIDTH  (COUNTER_WIDTH),
        .BAR_WIDTH   (BAR_WIDTH),
        .LOGARITHMIC (LOGARITHMIC),
        .BAR_STEP    (BAR_STEP)
    ) u_bar (
        .clock    (clock),
        .reset_n  (reset_n),
        .rate_i   (rate_q),
        .valid_i  (rate_vld_q),
        .bar_o    (bus.progress_bar_o),
        .update_o (bus.update_o)
    );

endmodule
